// File: rtl/rwm_frame_buffer_if.sv
// Controller/camera/grayscaler signal bundle for rwm_frame_buffer.
// The master side drives commands, camera words and out_ready; the slave side is the store.
interface rwm_frame_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 20
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_len;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len, abort, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, abort, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last, busy, done, err
    );
endinterface

// File: rtl/rwm_frame_buffer.sv
// Parametrised pixel frame store: commanded write, read and clear sweeps over a
// DEPTH-word synchronous RAM with wrapping addresses and abort.
module rwm_frame_buffer #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int HEIGHT   = 450,
    parameter int WIDTH    = 600,
    parameter int ADDR_W   = 20
) (
    input logic                clk,
    input logic                rst_n,
    rwm_frame_buffer_if.slave  bus
);
    localparam int DEPTH = CHANNELS * HEIGHT * WIDTH;
    localparam logic [ADDR_W-1:0] DEPTH_W   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, remaining, addr_inc;
    logic              done_q, err_q, done_next, err_next;
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic              accept, abort_hit, wr_beat, clr_beat, rd_load, rd_fin, last_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + ONE;
    assign last_cnt = (remaining == ONE);

    always_comb begin
        state_next = state;
        accept     = bus.cmd_valid && (state == IDLE);
        abort_hit  = bus.abort && (state != IDLE);
        wr_beat    = (state == WRITE) && bus.in_valid && !bus.abort;
        clr_beat   = (state == CLEAR) && !bus.abort;
        rd_load    = (state == READ) && !bus.abort && (!out_valid_q || bus.out_ready)
                     && (remaining != '0);
        rd_fin     = (state == READ) && out_valid_q && bus.out_ready && out_last_q;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        2'b00:   state_next = READ;
                        2'b01:   state_next = WRITE;
                        2'b10:   state_next = CLEAR;
                        default: err_next   = 1'b1;
                    endcase
                end
            end
            WRITE: begin
                if (wr_beat && last_cnt) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            READ: begin
                if (rd_fin && !bus.abort) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_beat && last_cnt) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides any completion landing in the same cycle.
        if (abort_hit) begin
            state_next = IDLE;
            done_next  = 1'b0;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            err_q  <= err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (accept) begin
            addr      <= bus.cmd_base;
            remaining <= (bus.cmd_len == '0) ? DEPTH_W : bus.cmd_len;
        end else if (wr_beat || clr_beat || rd_load) begin
            addr      <= addr_inc;
            remaining <= remaining - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_beat) begin
            mem[addr] <= bus.in_data;
        end else if (clr_beat) begin
            mem[addr] <= '0;
        end
    end

    // The RAM read register doubles as the output stage, so a stalled word simply isn't reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (abort_hit) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (rd_load) begin
            out_valid_q <= 1'b1;
            out_last_q  <= last_cnt;
            out_data_q  <= mem[addr];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.in_ready  = (state == WRITE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_rwm_frame_buffer.sv
// Scoreboarded bench for rwm_frame_buffer with a 12-word frame (3 x 2 x 2).
module tb_rwm_frame_buffer;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEP = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   exp_done = 0;
    int   exp_err = 0;

    typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] model [DEP];

    rwm_frame_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rwm_frame_buffer #(
        .DATA_W(DW), .CHANNELS(3), .HEIGHT(2), .WIDTH(2), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: the head of the queue must be on out_data whenever out_valid is up.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) done_cnt++;
            if (bus.err) err_cnt++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    if (bus.out_ready) check("rd_unexpected", {bus.out_last, bus.out_data}, 32'hFFFF);
                end else begin
                    check("rd_data", bus.out_data, exp_q[0].data);
                    check("rd_last", bus.out_last, exp_q[0].last);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] base, input logic [AW-1:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_check(input string name, input logic d, input logic e);
        @(negedge clk);
        check({name, "_done"}, bus.done, d);
        check({name, "_err"}, bus.err, e);
        check({name, "_busy"}, bus.busy, 1'b0);
        check({name, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({name, "_out_valid"}, bus.out_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_pulse_end"}, {bus.done, bus.err}, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input logic [DW-1:0] start, input int beats, input int abort_at);
        int n;
        n = (len == 0) ? DEP : int'(len);
        issue(2'b01, base, len);
        for (int i = 0; i < beats; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = start + DW'(i);
            bus.abort    = (i == abort_at);
            if (i == 0) begin
                @(negedge clk);
                check("wr_in_ready", bus.in_ready, 1'b1);
            end
            if (i != abort_at) model[(int'(base) + i) % DEP] = start + DW'(i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        if (abort_at >= 0) begin
            exp_err++;
            finish_check("wr_abort", 1'b0, 1'b1);
        end else begin
            exp_done++;
            check("wr_beats", beats, n);
            finish_check("wr", 1'b1, 1'b0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] base, input logic [AW-1:0] len, input bit stall);
        int n, k, first;
        n = (len == 0) ? DEP : int'(len);
        for (int i = 0; i < n; i++) exp_q.push_back({model[(int'(base) + i) % DEP], i == n - 1});
        issue(2'b00, base, len);
        k = 0;
        first = -1;
        while (exp_q.size() != 0 && k < 200) begin
            bus.out_ready = stall ? (k % 3 == 0) : 1'b1;
            @(negedge clk);
            if (first < 0 && bus.out_valid) first = k;
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b1;
        check("rd_first_valid_cycle", first, 1);
        check("rd_drained", exp_q.size(), 0);
        exp_done++;
        finish_check("rd", 1'b1, 1'b0);
    endtask

    initial begin
        int busy_cycles;
        logic d_seen;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        #12;
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_outputs", {bus.busy, bus.in_ready, bus.out_valid, bus.out_last,
                              bus.done, bus.err, bus.out_data}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_write(4'd0, 4'd0, 8'h01, 12, -1);
        do_read(4'd0, 4'd0, 1'b0);
        do_read(4'd0, 4'd0, 1'b1);

        do_write(4'd10, 4'd4, 8'hA0, 4, -1);
        do_read(4'd10, 4'd4, 1'b0);
        check("wrap_mem0", model[0], 8'hA2);
        do_read(4'd0, 4'd0, 1'b1);

        // Clear sweep: busy for exactly 12 cycles, then done.
        issue(2'b10, 4'd0, 4'd0);
        busy_cycles = 0;
        d_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.busy) begin
                d_seen = bus.done;
                break;
            end
            busy_cycles++;
        end
        for (int i = 0; i < DEP; i++) model[i] = '0;
        exp_done++;
        check("clr_busy_cycles", busy_cycles, 12);
        check("clr_done", d_seen, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("clr_done_pulse_end", bus.done, 1'b0);
        @(posedge clk); #1;
        do_read(4'd0, 4'd0, 1'b0);

        // Abort on the sixth beat: only 0x51..0x55 land, 0x56 is dropped.
        do_write(4'd0, 4'd0, 8'h51, 6, 5);
        do_read(4'd0, 4'd0, 1'b0);

        issue(2'b11, 4'd0, 4'd0);
        exp_err++;
        finish_check("illegal_op", 1'b0, 1'b1);

        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        finish_check("idle_abort", 1'b0, 1'b0);

        check("done_count", done_cnt, exp_done);
        check("err_count", err_cnt, exp_err);

        // Asynchronous reset in the middle of a stalled read.
        bus.out_ready = 1'b0;
        issue(2'b00, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_out_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_read", {bus.out_valid, bus.busy, bus.cmd_ready}, 3'b001);
        #20;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
